// File: rtl/dmem_responder.sv
// Single-port data memory for a soft processor: block RAM plus a small MMIO window
// (LED, free-running CYCLE counter, sticky error STATUS). One access per clock, 1-cycle read latency.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] led_out,
    output logic        err_sticky
);

    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [31:0] LED_ADDR    = MMIO_BASE;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'd1;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           ram_rd_reg;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  ram_en;

    logic in_ram;
    logic is_led;
    logic is_cycle;
    logic is_status;

    logic        sel_ram_reg, sel_ram_next;
    logic [31:0] q_mmio_reg,  q_mmio_next;
    logic [31:0] led_reg,     led_next;
    logic [31:0] cycle_reg,   cycle_next;
    logic        err_reg,     err_next;

    // RAM wins the decode if a parameter choice ever overlaps it with the MMIO window.
    always_comb begin
        in_ram    = (address_dmem[31:DEPTH_LOG2] == '0);
        is_led    = !in_ram && (address_dmem == LED_ADDR);
        is_cycle  = !in_ram && (address_dmem == CYCLE_ADDR);
        is_status = !in_ram && (address_dmem == STATUS_ADDR);
        ram_idx   = address_dmem[DEPTH_LOG2-1:0];
        ram_en    = reset && in_ram;
    end

    // Write-first block RAM; the read register only moves on RAM accesses so q can hold.
    always_ff @(posedge clock) begin
        if (ram_en) begin
            if (wren) begin
                mem[ram_idx] <= data;
                ram_rd_reg   <= data;
            end else begin
                ram_rd_reg   <= mem[ram_idx];
            end
        end
    end

    always_comb begin
        sel_ram_next = sel_ram_reg;
        q_mmio_next  = q_mmio_reg;
        led_next     = led_reg;
        cycle_next   = cycle_reg + 32'd1;
        err_next     = err_reg;
        if (in_ram) begin
            sel_ram_next = 1'b1;
        end else if (is_led) begin
            sel_ram_next = 1'b0;
            if (wren) begin
                led_next    = data;
                q_mmio_next = data;
            end else begin
                q_mmio_next = led_reg;
            end
        end else if (is_cycle) begin
            sel_ram_next = 1'b0;
            // The written value counts as this cycle's value, so the counter lands one past it.
            if (wren) begin
                cycle_next  = data + 32'd1;
                q_mmio_next = data;
            end else begin
                q_mmio_next = cycle_reg;
            end
        end else if (is_status) begin
            sel_ram_next = 1'b0;
            q_mmio_next  = {31'b0, err_reg};
        end else begin
            err_next = 1'b1;
            if (!wren) begin
                sel_ram_next = 1'b0;
                q_mmio_next  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_ram_reg <= 1'b0;
            q_mmio_reg  <= '0;
            led_reg     <= '0;
            cycle_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            sel_ram_reg <= sel_ram_next;
            q_mmio_reg  <= q_mmio_next;
            led_reg     <= led_next;
            cycle_reg   <= cycle_next;
            err_reg     <= err_next;
        end
    end

    assign q_dmem     = sel_ram_reg ? ram_rd_reg : q_mmio_reg;
    assign led_out    = led_reg;
    assign err_sticky = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a table of single-cycle vectors with hand-computed
// results, followed by a short streamed write/read-back sequence and an LED hold sequence.
module tb_dmem_responder;

    localparam logic [31:0] LED_A    = 32'h0000_FFF0;
    localparam logic [31:0] CYCLE_A  = 32'h0000_FFF1;
    localparam logic [31:0] STATUS_A = 32'h0000_FFF2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [31:0] led_out;
    logic        err_sticky;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] q;
        logic [31:0] led;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH_LOG2(10), .MMIO_BASE(32'h0000_FFF0)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .led_out      (led_out),
        .err_sticky   (err_sticky)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst_n, input logic wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] q, input logic [31:0] led,
                       input logic err);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.addr = addr; v.din = din;
        v.q = q; v.led = led; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst_n, input logic wr, input logic [31:0] addr,
                         input logic [31:0] din);
        @(negedge clock);
        reset        = rst_n;
        wren         = wr;
        address_dmem = addr;
        data         = din;
        @(posedge clock);
        #1;
        n_vec++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %08h, expected %08h", nm, idx, act, exp);
        end
    endtask

    logic [31:0] model [8];

    initial begin
        // Reset edge carrying a write that must be discarded; then CYCLE starts from 0.
        add(0, 1, 32'd3,       32'h0000_0777, 32'h0,          32'h0,  0);
        add(1, 0, CYCLE_A,     32'h0,         32'h0,          32'h0,  0);
        add(1, 0, CYCLE_A,     32'h0,         32'h1,          32'h0,  0);
        add(1, 1, 32'd5,       32'hDEAD_BEEF, 32'hDEAD_BEEF,  32'h0,  0);
        add(1, 0, 32'd5,       32'h0,         32'hDEAD_BEEF,  32'h0,  0);
        add(1, 1, 32'd7,       32'h0000_1234, 32'h0000_1234,  32'h0,  0);
        add(1, 0, 32'd7,       32'h0,         32'h0000_1234,  32'h0,  0);
        add(1, 1, 32'd3,       32'h3333_0003, 32'h3333_0003,  32'h0,  0);
        add(1, 1, 32'd0,       32'h0000_AAAA, 32'h0000_AAAA,  32'h0,  0);
        add(1, 1, 32'd1023,    32'hC0DE_03FF, 32'hC0DE_03FF,  32'h0,  0);
        add(1, 0, 32'd5,       32'h0,         32'hDEAD_BEEF,  32'h0,  0);
        add(1, 1, LED_A,       32'h0000_00A5, 32'h0000_00A5,  32'hA5, 0);
        add(1, 0, LED_A,       32'h0,         32'h0000_00A5,  32'hA5, 0);
        add(1, 0, STATUS_A,    32'h0,         32'h0,          32'hA5, 0);
        add(1, 1, STATUS_A,    32'hFFFF_FFFF, 32'h0,          32'hA5, 0);
        add(1, 0, 32'h400,     32'h0,         32'h0,          32'hA5, 1);
        add(1, 0, 32'd1023,    32'h0,         32'hC0DE_03FF,  32'hA5, 1);
        add(1, 0, STATUS_A,    32'h0,         32'h1,          32'hA5, 1);
        add(1, 1, 32'h1234_5678, 32'h55,      32'h1,          32'hA5, 1);
        add(1, 1, STATUS_A,    32'h0,         32'h1,          32'hA5, 1);
        add(1, 1, CYCLE_A,     32'hFFFF_FFFE, 32'hFFFF_FFFE,  32'hA5, 1);
        add(1, 0, CYCLE_A,     32'h0,         32'hFFFF_FFFF,  32'hA5, 1);
        add(1, 0, CYCLE_A,     32'h0,         32'h0,          32'hA5, 1);
        add(1, 0, CYCLE_A,     32'h0,         32'h1,          32'hA5, 1);
        add(1, 0, 32'd5,       32'h0,         32'hDEAD_BEEF,  32'hA5, 1);
        add(1, 0, 32'h0000_FFF3, 32'h0,       32'h0,          32'hA5, 1);
        add(1, 0, 32'd5,       32'h0,         32'hDEAD_BEEF,  32'hA5, 1);
        add(1, 0, 32'h8000_0005, 32'h0,       32'h0,          32'hA5, 1);
        // Mid-sequence reset with a write in flight: nothing may land in addr 3.
        add(0, 1, 32'd3,       32'h0000_0BAD, 32'h0,          32'h0,  0);
        add(1, 0, 32'd3,       32'h0,         32'h3333_0003,  32'h0,  0);
        add(1, 0, 32'd7,       32'h0,         32'h0000_1234,  32'h0,  0);
        add(1, 1, 32'h400,     32'h0000_0099, 32'h0000_1234,  32'h0,  1);
        add(1, 0, 32'd0,       32'h0,         32'h0000_AAAA,  32'h0,  1);
        add(1, 0, 32'd1023,    32'h0,         32'hC0DE_03FF,  32'h0,  1);

        apply(0, 0, 32'h0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].wr, vecs[i].addr, vecs[i].din);
            $display("vec %0d: rst_n=%0b wr=%0b addr=%08h din=%08h -> q=%08h led=%08h err=%0b",
                     i, vecs[i].rst_n, vecs[i].wr, vecs[i].addr, vecs[i].din,
                     q_dmem, led_out, err_sticky);
            chk("q_dmem", i, q_dmem, vecs[i].q);
            chk("led_out", i, led_out, vecs[i].led);
            chk("err_sticky", i, {31'b0, err_sticky}, {31'b0, vecs[i].err});
        end

        // Streamed writes, then read back in reverse order against a local model.
        for (int i = 0; i < 8; i++) begin
            model[i] = 32'hA000_0000 + 32'(i) * 32'h0000_0111;
            apply(1, 1, 32'd100 + 32'(i), model[i]);
            $display("stream wr addr=%0d din=%08h -> q=%08h", 100 + i, model[i], q_dmem);
            chk("stream_wr_q", i, q_dmem, model[i]);
        end
        for (int i = 7; i >= 0; i--) begin
            apply(1, 0, 32'd100 + 32'(i), 32'h0);
            $display("stream rd addr=%0d -> q=%08h", 100 + i, q_dmem);
            chk("stream_rd_q", i, q_dmem, model[i]);
        end

        // LED holds across unrelated accesses.
        apply(1, 1, LED_A, 32'h0000_5A5A);
        $display("led wr 00005a5a -> led=%08h", led_out);
        chk("led_wr", 0, led_out, 32'h0000_5A5A);
        for (int i = 0; i < 3; i++) begin
            apply(1, (i == 1), 32'd200 + 32'(i), 32'h1111_0000 + 32'(i));
            $display("led hold step %0d -> led=%08h q=%08h", i, led_out, q_dmem);
            chk("led_hold", i, led_out, 32'h0000_5A5A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-low.
REQ-002 Parameter: DEPTH_LOG2, default 10, log2 of the RAM word count (1024 x 32-bit words).
REQ-003 Parameter: MMIO_BASE, default 32'h0000_FFF0, base word address of the memory-mapped register window.
REQ-004 Port: clock  input  1  master clock; all state SHALL update on the rising edge only.
REQ-005 Port: reset  input  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-006 Port: address_dmem  input  32  word address from the processor data port.
REQ-007 Port: data  input  32  store data from the processor.
REQ-008 Port: wren  input  1  store strobe; 1 = write this cycle, 0 = read this cycle.
REQ-009 Port: q_dmem  output  32  registered load data returned to the processor.
REQ-010 Port: led_out  output  32  contents of the LED register.
REQ-011 Port: err_sticky  output  1  set on any out-of-range access; cleared only by reset.

Function
REQ-012 Every cycle SHALL be one access: a write if wren=1, otherwise a read.
REQ-013 The address decode SHALL be exactly one of three regions:
- RAM: address_dmem[31:DEPTH_LOG2]==0.
- MMIO: address_dmem in MMIO_BASE..MMIO_BASE+2.
- Out-of-range: any other address.
REQ-014 Read latency SHALL be exactly 1 cycle: q_dmem after edge N SHALL reflect the address presented before edge N.
REQ-015 q_dmem SHALL hold its value until the next access updates it.
REQ-016 A RAM write SHALL commit at the rising edge.
REQ-017 A write cycle SHALL be write-first: q_dmem after the edge SHALL equal the data written.
REQ-018 A read in cycle N+1 of an address written in cycle N SHALL return the new value; no stale data is allowed.
REQ-019 MMIO word MMIO_BASE+0 (LED): a write SHALL load led_out; a read SHALL return led_out.
REQ-020 MMIO word MMIO_BASE+1 (CYCLE): free-running 32-bit counter.
- SHALL increment by 1 every cycle out of reset.
- SHALL wrap from 32'hFFFF_FFFF to 0.
- A write SHALL load it with data, and it SHALL increment from that value on the following cycle.
- A read SHALL return the value before the edge's increment.
REQ-021 MMIO word MMIO_BASE+2 (STATUS): reads SHALL return {31'b0, err_sticky}; writes SHALL be ignored.
REQ-022 An out-of-range write SHALL modify no state except err_sticky.
REQ-023 An out-of-range read SHALL drive q_dmem to 0 and set err_sticky.
REQ-024 The top RAM word (2^DEPTH_LOG2 - 1) SHALL be valid RAM; the next address SHALL be out-of-range.
REQ-025 The write-first rule (REQ-017) SHALL also apply to LED and CYCLE writes; the q_dmem value after a STATUS write SHALL be the STATUS read value.
REQ-026 X or Z on address_dmem while wren=0 SHALL NOT corrupt RAM contents.

Reset
REQ-027 When reset=0 at a rising edge, the following SHALL all be 0 after that edge:
- q_dmem
- led_out
- err_sticky
- CYCLE counter
REQ-028 RAM contents SHALL NOT be altered by reset.
REQ-029 An access presented in a reset cycle SHALL be discarded, including writes.
REQ-030 The first access SHALL be accepted on the first edge with reset=1.
REQ-031 Reset asserted mid-sequence SHALL take effect on that same edge, with no partial write.

Verification
REQ-032 Write 32'hDEAD_BEEF to addr 5, then read addr 5 on the next cycle -> q_dmem=32'hDEAD_BEEF one cycle after the read.
REQ-033 Write 32'h1234 to addr 7, then immediately read addr 7 -> q_dmem=32'h1234 after both the write edge and the read edge.
REQ-034 Read addr 32'h0000_0400 (DEPTH_LOG2=10) -> q_dmem=0 and err_sticky=1. Then read addr 1023 -> RAM data, with err_sticky still 1.
REQ-035 Write 32'hFFFF_FFFE to CYCLE, then read CYCLE on each of the next three cycles -> q_dmem=FFFF_FFFF, 0000_0000, 0000_0001.
REQ-036 Write 32'hA5 to LED and set err_sticky, then assert reset=0 for one edge with wren=1 to addr 3 -> led_out=0, err_sticky=0, q_dmem=0, addr 3 unchanged.
